// File: rtl/adder_pkg.sv
// Shared sizing helpers for the carry-save multi-operand adder.
package adder_pkg;

    localparam int ACC_W_DEFAULT = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Width that holds the exact sum of n_ops unsigned op_w-bit operands.
    function automatic int sum_w(input int n_ops, input int op_w);
        return op_w + clog2(n_ops);
    endfunction

    // Rows left after one 3:2 level: each full triple becomes two rows,
    // the remainder (rows mod 3) passes straight through.
    function automatic int rows_next(input int rows);
        return (rows / 3) * 2 + (rows % 3);
    endfunction

    // Row count entering a given tree level.
    function automatic int rows_at(input int n_ops, input int level);
        int r;
        r = n_ops;
        for (int i = 0; i < level; i++) begin
            r = rows_next(r);
        end
        return r;
    endfunction

    // Number of 3:2 levels needed to get down to two rows.
    function automatic int tree_levels(input int n_ops);
        int r;
        int l;
        r = n_ops;
        l = 0;
        while (r > 2) begin
            r = rows_next(r);
            l = l + 1;
        end
        return l;
    endfunction

endpackage

// File: rtl/csa_row.sv
// One vector 3:2 compressor: three rows in, sum row and carry row out.
// The carry row is shifted left by one; its top bit is dropped, which is
// safe because the tree width already holds the full exact total.
module csa_row #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum_row,
    output logic [W-1:0] carry_row
);

    assign sum_row   = a ^ b ^ c;
    assign carry_row = {(a[W-2:0] & b[W-2:0]) |
                        (a[W-2:0] & c[W-2:0]) |
                        (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/csa_sum_pipe.sv
// Pipelined multi-operand unsigned adder: carry-save tree into stage A,
// carry-propagate add plus saturating group accumulator into stage B.
module csa_sum_pipe
    import adder_pkg::*;
#(
    parameter int N_OPS = 12,
    parameter int OP_W  = 3,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_OPS*OP_W-1:0] in_ops,
    input  logic                  in_acc,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_sum,
    output logic                  out_ovf
);

    localparam int SUM_W  = sum_w(N_OPS, OP_W);
    localparam int LEVELS = tree_levels(N_OPS);

    // ---------------- carry-save reduction tree ----------------
    logic [SUM_W-1:0] op_ext [N_OPS];

    genvar gi;
    genvar gl;

    for (gi = 0; gi < N_OPS; gi++) begin : g_ext
        assign op_ext[gi] = SUM_W'(in_ops[gi*OP_W +: OP_W]);
    end

    for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
        localparam int R_IN  = rows_at(N_OPS, gl);
        localparam int GRP   = R_IN / 3;
        localparam int REM   = R_IN % 3;
        localparam int R_OUT = 2 * GRP + REM;

        logic [SUM_W-1:0] rows_in  [R_IN];
        logic [SUM_W-1:0] rows_out [R_OUT];

        if (gl == 0) begin : g_src_ops
            for (gi = 0; gi < R_IN; gi++) begin : g_in
                assign rows_in[gi] = op_ext[gi];
            end
        end else begin : g_src_prev
            for (gi = 0; gi < R_IN; gi++) begin : g_in
                assign rows_in[gi] = g_lvl[gl-1].rows_out[gi];
            end
        end

        for (gi = 0; gi < GRP; gi++) begin : g_csa
            csa_row #(.W(SUM_W)) u_row (
                .a         (rows_in[3*gi]),
                .b         (rows_in[3*gi+1]),
                .c         (rows_in[3*gi+2]),
                .sum_row   (rows_out[2*gi]),
                .carry_row (rows_out[2*gi+1])
            );
        end

        for (gi = 0; gi < REM; gi++) begin : g_pass
            assign rows_out[2*GRP+gi] = rows_in[3*GRP+gi];
        end
    end

    logic [SUM_W-1:0] tree_sv;
    logic [SUM_W-1:0] tree_cv;
    assign tree_sv = g_lvl[LEVELS-1].rows_out[0];
    assign tree_cv = g_lvl[LEVELS-1].rows_out[1];

    // ---------------- handshake ----------------
    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ---------------- stage A ----------------
    logic [SUM_W-1:0] a_sv;
    logic [SUM_W-1:0] a_cv;
    logic             a_acc;
    logic             a_last;
    logic             a_valid;

    // Capture the reduced sum/carry pair; everything holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_sv    <= '0;
            a_cv    <= '0;
            a_acc   <= 1'b0;
            a_last  <= 1'b0;
        end else if (!stall) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_sv   <= tree_sv;
                a_cv   <= tree_cv;
                a_acc  <= in_acc;
                a_last <= in_last;
            end
        end
    end

    // ---------------- stage B ----------------
    logic [SUM_W-1:0] beat_sum;
    logic [ACC_W:0]   acc_sum;
    logic             sat_hit;
    logic [ACC_W-1:0] acc_clamped;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    // The tree width holds the exact total, so the modular add is exact.
    assign beat_sum    = a_sv + a_cv;
    assign acc_sum     = {1'b0, acc} + (ACC_W+1)'(beat_sum);
    assign sat_hit     = acc_sum[ACC_W];
    assign acc_clamped = sat_hit ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

    // Emit plain beats directly, fold accumulate beats into acc and emit
    // the saturated total on the last beat of a group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (!stall) begin
            out_valid <= 1'b0;
            if (a_valid) begin
                if (!a_acc) begin
                    out_valid <= 1'b1;
                    out_sum   <= ACC_W'(beat_sum);
                    out_ovf   <= 1'b0;
                end else if (!a_last) begin
                    acc <= acc_clamped;
                    ovf <= ovf | sat_hit;
                end else begin
                    out_valid <= 1'b1;
                    out_sum   <= acc_clamped;
                    out_ovf   <= ovf | sat_hit;
                    acc       <= '0;
                    ovf       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_csa_sum_pipe.sv
// Self-checking bench for csa_sum_pipe: directed steps with a scoreboard
// queue filled on accept and drained by an output monitor.
module tb_csa_sum_pipe;

    localparam int N_OPS    = 12;
    localparam int OP_W     = 3;
    localparam int ACC_W    = 16;
    localparam int OPS_BITS = N_OPS * OP_W;
    localparam int ACC_MAX  = (1 << ACC_W) - 1;

    typedef struct {
        int sum;
        int ovf;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [OPS_BITS-1:0] in_ops = '0;
    logic                in_acc = 1'b0;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [ACC_W-1:0]    out_sum;
    logic                out_ovf;

    // Narrow-accumulator instance for the saturation case.
    logic                v8 = 1'b0;
    logic                rdy8;
    logic [OPS_BITS-1:0] ops8 = '0;
    logic                acc8 = 1'b0;
    logic                last8 = 1'b0;
    logic                ov8;
    logic                or8 = 1'b1;
    logic [7:0]          sum8;
    logic                ovf8;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   n_out    = 0;
    int   cyc      = 0;
    int   model_acc = 0;
    int   model_ovf = 0;
    exp_t sb[$];

    csa_sum_pipe #(.N_OPS(N_OPS), .OP_W(OP_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ops    (in_ops),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    csa_sum_pipe #(.N_OPS(N_OPS), .OP_W(OP_W), .ACC_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .in_ready  (rdy8),
        .in_ops    (ops8),
        .in_acc    (acc8),
        .in_last   (last8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_sum   (sum8),
        .out_ovf   (ovf8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [OPS_BITS-1:0] ops_const(input int v);
        logic [OPS_BITS-1:0] r;
        r = '0;
        for (int k = 0; k < N_OPS; k++) r[k*OP_W +: OP_W] = OP_W'(v);
        return r;
    endfunction

    function automatic logic [OPS_BITS-1:0] ops_mod8();
        logic [OPS_BITS-1:0] r;
        r = '0;
        for (int k = 0; k < N_OPS; k++) r[k*OP_W +: OP_W] = OP_W'(k % 8);
        return r;
    endfunction

    // Reference: exact beat sum, then group accumulation with clamping.
    task automatic model_push(input logic [OPS_BITS-1:0] ops, input logic acc, input logic last);
        int   s;
        int   t;
        int   hit;
        exp_t e;
        s = 0;
        for (int k = 0; k < N_OPS; k++) s += int'(ops[k*OP_W +: OP_W]);
        if (!acc) begin
            e.sum = s;
            e.ovf = 0;
            sb.push_back(e);
        end else begin
            t   = model_acc + s;
            hit = 0;
            if (t > ACC_MAX) begin
                t   = ACC_MAX;
                hit = 1;
            end
            if (last) begin
                e.sum = t;
                e.ovf = model_ovf | hit;
                sb.push_back(e);
                model_acc = 0;
                model_ovf = 0;
            end else begin
                model_acc = t;
                model_ovf = model_ovf | hit;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [OPS_BITS-1:0] ops, input logic acc, input logic last);
        logic ready_seen;
        int   waited;
        in_valid = 1'b1;
        in_ops   = ops;
        in_acc   = acc;
        in_last  = last;
        waited   = 0;
        forever begin
            @(negedge clk);
            ready_seen = in_ready;
            @(posedge clk);
            #1;
            if (ready_seen) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", int'(ready_seen), 1);
                break;
            end
        end
        in_valid = 1'b0;
        if (ready_seen) model_push(ops, acc, last);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send8(input logic [OPS_BITS-1:0] ops, input logic acc, input logic last);
        v8    = 1'b1;
        ops8  = ops;
        acc8  = acc;
        last8 = last;
        @(posedge clk);
        #1;
        v8 = 1'b0;
    endtask

    task automatic wait8(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!ov8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(ov8), 1);
    endtask

    // Output monitor: every handshake pops and compares one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", int'(out_valid), 0);
            end else begin
                e = sb.pop_front();
                $display("out #%0d: sum=%0d ovf=%0d (expect %0d/%0d)", n_out, out_sum, out_ovf, e.sum, e.ovf);
                check("out_sum", int'(out_sum), e.sum);
                check("out_ovf", int'(out_ovf), e.ovf);
                n_out++;
            end
        end
    end

    initial begin
        int c0;
        int o0;
        logic [OPS_BITS-1:0] r;

        // Reset state
        #1 rst_n = 1'b0;
        #11;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All 7s, plain beat, with latency check
        send(ops_const(7), 1'b0, 1'b0);
        @(negedge clk);
        check("lat_edge1_valid", int'(out_valid), 0);
        @(negedge clk);
        check("lat_edge2_valid", int'(out_valid), 1);
        check("lat_edge2_sum", int'(out_sum), 84);
        @(posedge clk);
        #1;
        send(ops_const(0), 1'b0, 1'b0);
        send(ops_mod8(), 1'b0, 1'b0);
        idle(3);

        // Random stream, back to back
        c0 = cyc;
        o0 = n_out;
        for (int i = 0; i < 100; i++) begin
            r = {$urandom, $urandom};
            send(r, 1'b0, 1'b0);
        end
        check("stream_cycles", cyc - c0, 100);
        idle(4);
        check("stream_outputs", n_out - o0, 100);

        // Accumulate 3 beats of 84 -> single 252
        o0 = n_out;
        send(ops_const(7), 1'b1, 1'b0);
        send(ops_const(7), 1'b1, 1'b0);
        idle(3);
        check("acc_no_early_out", n_out - o0, 0);
        send(ops_const(7), 1'b1, 1'b1);
        idle(3);
        check("acc_one_out", n_out - o0, 1);

        // Plain beat inside a group leaves acc alone: 34 + 84 = 118
        send(ops_mod8(), 1'b1, 1'b0);
        send(ops_const(7), 1'b0, 1'b0);
        send(ops_const(7), 1'b1, 1'b1);
        send(ops_const(7), 1'b1, 1'b1);
        idle(3);

        // Stall: output held 5 cycles, input blocked, nothing lost
        out_ready = 1'b0;
        send(ops_const(5), 1'b0, 1'b0);
        send(ops_mod8(), 1'b0, 1'b0);
        in_valid = 1'b1;
        in_ops   = ops_const(3);
        in_acc   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_out_sum", int'(out_sum), 60);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(ops_const(3), 1'b0, 1'b0);
        idle(4);

        // Reset in the middle of a group
        send(ops_const(7), 1'b1, 1'b0);
        send(ops_const(7), 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        model_acc = 0;
        model_ovf = 0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_sum", int'(out_sum), 0);
        check("midrst_out_ovf", int'(out_ovf), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(ops_const(7), 1'b1, 1'b1);
        idle(4);

        // Saturation on the 8-bit accumulator instance
        send8(ops_const(7), 1'b1, 1'b0);
        send8(ops_const(7), 1'b1, 1'b0);
        send8(ops_const(7), 1'b1, 1'b0);
        send8(ops_const(7), 1'b1, 1'b1);
        wait8("sat_valid");
        $display("acc8 group: sum=%0d ovf=%0d", sum8, ovf8);
        check("sat_sum", int'(sum8), 255);
        check("sat_ovf", int'(ovf8), 1);
        @(posedge clk);
        #1;
        send8(ops_const(7), 1'b1, 1'b1);
        wait8("post_sat_valid");
        $display("acc8 group: sum=%0d ovf=%0d", sum8, ovf8);
        check("post_sat_sum", int'(sum8), 84);
        check("post_sat_ovf", int'(ovf8), 0);
        idle(2);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
